// File: rtl/otter_exec_unit.sv
// OTTER execute stage: ALU, branch condition generator and branch address generator, plus the EX/MEM result register.
// Define OTTER_EXEC_JALR_ALIGN_EN to clear bit 0 of the JALR target.
module otter_exec_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic        CLR,
    input  logic [3:0]  ALU_FUN,
    input  logic [31:0] SRC_A,
    input  logic [31:0] SRC_B,
    input  logic [31:0] RS1,
    input  logic [31:0] RS2,
    input  logic [31:0] PC,
    input  logic [31:0] I_TYPE,
    input  logic [31:0] J_TYPE,
    input  logic [31:0] B_TYPE,
    output logic [31:0] RESULT,
    output logic [31:0] RESULT_Q,
    output logic        BR_EQ,
    output logic        BR_LT,
    output logic        BR_LTU,
    output logic [31:0] JAL,
    output logic [31:0] JALR,
    output logic [31:0] BRANCH
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_LUI  = 4'b1001,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    alu_op_e     w_op;
    logic [4:0]  w_shamt;
    logic [31:0] w_alu;
    logic [31:0] w_jalr_sum;
    logic [31:0] r_result_q;

    assign w_op    = alu_op_e'(ALU_FUN);
    assign w_shamt = SRC_B[4:0];

    // Unlisted encodings fall through to zero.
    always_comb begin
        w_alu = '0;
        case (w_op)
            ALU_ADD:  w_alu = SRC_A + SRC_B;
            ALU_SUB:  w_alu = SRC_A - SRC_B;
            ALU_SLL:  w_alu = SRC_A << w_shamt;
            ALU_SLT:  w_alu = {31'd0, $signed(SRC_A) < $signed(SRC_B)};
            ALU_SLTU: w_alu = {31'd0, SRC_A < SRC_B};
            ALU_XOR:  w_alu = SRC_A ^ SRC_B;
            ALU_SRL:  w_alu = SRC_A >> w_shamt;
            ALU_SRA:  w_alu = $unsigned($signed(SRC_A) >>> w_shamt);
            ALU_OR:   w_alu = SRC_A | SRC_B;
            ALU_AND:  w_alu = SRC_A & SRC_B;
            ALU_LUI:  w_alu = SRC_A;
            default:  w_alu = '0;
        endcase
    end

    assign RESULT = w_alu;

    assign BR_EQ  = (RS1 == RS2);
    assign BR_LT  = ($signed(RS1) < $signed(RS2));
    assign BR_LTU = (RS1 < RS2);

    assign JAL        = PC + J_TYPE;
    assign BRANCH     = PC + B_TYPE;
    assign w_jalr_sum = RS1 + I_TYPE;

`ifdef OTTER_EXEC_JALR_ALIGN_EN
    assign JALR = {w_jalr_sum[31:1], 1'b0};
`else
    assign JALR = w_jalr_sum;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_result_q <= '0;
        end else if (CLR) begin
            r_result_q <= '0;
        end else if (EN) begin
            r_result_q <= w_alu;
        end
    end

    assign RESULT_Q = r_result_q;

endmodule

// File: tb/tb_otter_exec_unit.sv
// Self-checking bench for otter_exec_unit: directed plan vectors plus randomized checks against an arithmetic reference model.
module tb_otter_exec_unit;

    logic        CLK = 1'b0;
    logic        RST, EN, CLR;
    logic [3:0]  ALU_FUN;
    logic [31:0] SRC_A, SRC_B, RS1, RS2, PC, I_TYPE, J_TYPE, B_TYPE;
    logic [31:0] RESULT, RESULT_Q, JAL, JALR, BRANCH;
    logic        BR_EQ, BR_LT, BR_LTU;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    otter_exec_unit dut (
        .CLK(CLK), .RST(RST), .EN(EN), .CLR(CLR), .ALU_FUN(ALU_FUN),
        .SRC_A(SRC_A), .SRC_B(SRC_B), .RS1(RS1), .RS2(RS2), .PC(PC),
        .I_TYPE(I_TYPE), .J_TYPE(J_TYPE), .B_TYPE(B_TYPE),
        .RESULT(RESULT), .RESULT_Q(RESULT_Q),
        .BR_EQ(BR_EQ), .BR_LT(BR_LT), .BR_LTU(BR_LTU),
        .JAL(JAL), .JALR(JALR), .BRANCH(BRANCH)
    );

    always #5 CLK = ~CLK;

    localparam longint MASK = 64'h0000_0000_FFFF_FFFF;

    function automatic longint sx(input logic [31:0] v);
        longint u;
        u = longint'(v);
        return (u >= 64'sh8000_0000) ? u - 64'sh1_0000_0000 : u;
    endfunction

    // Reference ALU from plain 64-bit integer arithmetic.
    function automatic logic [31:0] alu_model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        longint ua, ub, sa, sb, p2;
        int     sh;
        ua = longint'(a); ub = longint'(b);
        sa = sx(a);       sb = sx(b);
        sh = int'(b % 32);
        p2 = longint'(1) << sh;
        case (f)
            4'd0:  return 32'((ua + ub) & MASK);
            4'd8:  return 32'((ua - ub + 64'h1_0000_0000) & MASK);
            4'd1:  return 32'((ua * p2) & MASK);
            4'd2:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd3:  return (ua < ub) ? 32'd1 : 32'd0;
            4'd4:  return a ^ b;
            4'd5:  return 32'(ua / p2);
            4'd13: return 32'(((sa < 0) ? (sa - p2 + 1) / p2 : sa / p2) & MASK);
            4'd6:  return a | b;
            4'd7:  return a & b;
            4'd9:  return a;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] jalr_model(input logic [31:0] r, input logic [31:0] i);
        longint s;
        s = (longint'(r) + longint'(i)) & MASK;
`ifdef OTTER_EXEC_JALR_ALIGN_EN
        if (s % 2 == 1) s = s - 1;
`endif
        return 32'(s);
    endfunction

    task automatic idle_inputs();
        RST = 0; EN = 0; CLR = 0; ALU_FUN = 4'd0;
        SRC_A = '0; SRC_B = '0; RS1 = '0; RS2 = '0; PC = '0;
        I_TYPE = '0; J_TYPE = '0; B_TYPE = '0;
    endtask

    task automatic test_reset();
        ALU_FUN = 4'd0; SRC_A = 32'd3; SRC_B = 32'd4; EN = 1; CLR = 0; RST = 1;
        @(posedge CLK); #1;
        vectors++;
        if (RESULT_Q !== 32'd0) begin
            miscompares++; $display("FAIL reset_q: got %h expected %h", RESULT_Q, 32'd0);
        end
        vectors++;
        if (RESULT !== 32'd7) begin
            miscompares++; $display("FAIL reset_comb: got %h expected %h", RESULT, 32'd7);
        end
        RST = 0; EN = 0;
    endtask

    task automatic test_alu_sweep();
        logic [3:0]  codes [9] = '{4'd0, 4'd8, 4'd5, 4'd13, 4'd1, 4'd2, 4'd3, 4'd9, 4'd15};
        logic [31:0] exp   [9] = '{32'h8000_0014, 32'h8000_000C, 32'h0800_0001, 32'hF800_0001,
                                   32'h0000_0100, 32'h1, 32'h0, 32'h8000_0010, 32'h0};
        SRC_A = 32'h8000_0010; SRC_B = 32'h0000_0004;
        for (int i = 0; i < 9; i++) begin
            ALU_FUN = codes[i]; #1;
            vectors++;
            if (RESULT !== exp[i]) begin
                miscompares++;
                $display("FAIL alu_sweep fun=%b: got %h expected %h", codes[i], RESULT, exp[i]);
            end
        end
    endtask

    task automatic test_shift_mask();
        ALU_FUN = 4'd1; SRC_A = 32'd1; SRC_B = 32'h0000_0021; #1;
        vectors++;
        if (RESULT !== 32'h2) begin
            miscompares++; $display("FAIL shift_mask: got %h expected %h", RESULT, 32'h2);
        end
    endtask

    task automatic test_bcg();
        RS1 = 32'hFFFF_FFFF; RS2 = 32'd1; #1;
        vectors++;
        if ({BR_EQ, BR_LT, BR_LTU} !== 3'b010) begin
            miscompares++; $display("FAIL bcg_neg: got %b expected %b", {BR_EQ, BR_LT, BR_LTU}, 3'b010);
        end
        RS1 = 32'd5; RS2 = 32'd5; #1;
        vectors++;
        if ({BR_EQ, BR_LT, BR_LTU} !== 3'b100) begin
            miscompares++; $display("FAIL bcg_eq: got %b expected %b", {BR_EQ, BR_LT, BR_LTU}, 3'b100);
        end
    endtask

    task automatic test_bag();
        PC = 32'h100; J_TYPE = 32'hFFFF_FFF8; B_TYPE = 32'h10; #1;
        vectors++;
        if (JAL !== 32'hF8) begin
            miscompares++; $display("FAIL bag_jal: got %h expected %h", JAL, 32'hF8);
        end
        vectors++;
        if (BRANCH !== 32'h110) begin
            miscompares++; $display("FAIL bag_branch: got %h expected %h", BRANCH, 32'h110);
        end
    endtask

    task automatic test_jalr();
        logic [31:0] exp;
`ifdef OTTER_EXEC_JALR_ALIGN_EN
        exp = 32'h204;
`else
        exp = 32'h205;
`endif
        RS1 = 32'h201; I_TYPE = 32'h4; #1;
        vectors++;
        if (JALR !== exp) begin
            miscompares++; $display("FAIL jalr_align: got %h expected %h", JALR, exp);
        end
    endtask

    task automatic test_register_control();
        ALU_FUN = 4'd0; SRC_A = 32'd3; SRC_B = 32'd4; EN = 1; CLR = 0; RST = 0;
        @(posedge CLK); #1;
        vectors++;
        if (RESULT_Q !== 32'd7) begin
            miscompares++; $display("FAIL reg_capture: got %h expected %h", RESULT_Q, 32'd7);
        end
        EN = 0; SRC_A = 32'd10; SRC_B = 32'd20;
        @(posedge CLK); #1;
        vectors++;
        if (RESULT_Q !== 32'd7) begin
            miscompares++; $display("FAIL reg_stall: got %h expected %h", RESULT_Q, 32'd7);
        end
        CLR = 1;
        @(posedge CLK); #1;
        vectors++;
        if (RESULT_Q !== 32'd0) begin
            miscompares++; $display("FAIL reg_clr: got %h expected %h", RESULT_Q, 32'd0);
        end
        CLR = 0; EN = 1; SRC_A = 32'd3; SRC_B = 32'd4;
        @(posedge CLK); #1;
        vectors++;
        if (RESULT_Q !== 32'd7) begin
            miscompares++; $display("FAIL reg_reload: got %h expected %h", RESULT_Q, 32'd7);
        end
        RST = 1;
        @(posedge CLK); #1;
        vectors++;
        if (RESULT_Q !== 32'd0) begin
            miscompares++; $display("FAIL reg_rst: got %h expected %h", RESULT_Q, 32'd0);
        end
        RST = 0; EN = 0;
    endtask

    task automatic test_random_alu();
        logic [31:0] exp;
        for (int i = 0; i < 300; i++) begin
            ALU_FUN = 4'($urandom_range(0, 15));
            SRC_A = $urandom;
            SRC_B = (i % 4 == 0) ? SRC_A : $urandom;
            #1;
            exp = alu_model(ALU_FUN, SRC_A, SRC_B);
            vectors++;
            if (RESULT !== exp) begin
                miscompares++;
                $display("FAIL rand_alu fun=%b a=%h b=%h: got %h expected %h", ALU_FUN, SRC_A, SRC_B, RESULT, exp);
            end
        end
    endtask

    task automatic test_random_branch();
        logic [2:0]  exp_c;
        logic [31:0] exp_jal, exp_br, exp_jalr;
        for (int i = 0; i < 200; i++) begin
            RS1 = $urandom; RS2 = (i % 5 == 0) ? RS1 : $urandom;
            PC = $urandom; I_TYPE = $urandom; J_TYPE = $urandom; B_TYPE = $urandom;
            #1;
            exp_c    = {RS1 == RS2, sx(RS1) < sx(RS2), longint'(RS1) < longint'(RS2)};
            exp_jal  = 32'((longint'(PC) + longint'(J_TYPE)) & MASK);
            exp_br   = 32'((longint'(PC) + longint'(B_TYPE)) & MASK);
            exp_jalr = jalr_model(RS1, I_TYPE);
            vectors++;
            if ({BR_EQ, BR_LT, BR_LTU} !== exp_c) begin
                miscompares++;
                $display("FAIL rand_bcg rs1=%h rs2=%h: got %b expected %b", RS1, RS2, {BR_EQ, BR_LT, BR_LTU}, exp_c);
            end
            vectors++;
            if ({JAL, BRANCH, JALR} !== {exp_jal, exp_br, exp_jalr}) begin
                miscompares++;
                $display("FAIL rand_bag: got jal=%h br=%h jalr=%h expected jal=%h br=%h jalr=%h",
                         JAL, BRANCH, JALR, exp_jal, exp_br, exp_jalr);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] model_q = 32'd0;
        RST = 1; @(posedge CLK); #1; RST = 0;
        for (int i = 0; i < 300; i++) begin
            ALU_FUN = 4'($urandom_range(0, 15));
            SRC_A = $urandom; SRC_B = $urandom;
            EN  = 1'($urandom_range(0, 1));
            CLR = ($urandom_range(0, 7) == 0);
            RST = ($urandom_range(0, 15) == 0);
            if (RST || CLR) model_q = 32'd0;
            else if (EN) model_q = alu_model(ALU_FUN, SRC_A, SRC_B);
            @(posedge CLK); #1;
            vectors++;
            if (RESULT_Q !== model_q) begin
                miscompares++;
                $display("FAIL rand_reg cyc=%0d rst=%b clr=%b en=%b: got %h expected %h",
                         i, RST, CLR, EN, RESULT_Q, model_q);
            end
        end
        RST = 0; CLR = 0; EN = 0;
    endtask

    initial begin
        idle_inputs();
        @(negedge CLK);
        test_reset();
        test_alu_sweep();
        test_shift_mask();
        test_bcg();
        test_bag();
        test_jalr();
        test_register_control();
        test_random_alu();
        test_random_branch();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
